mux_10to5: RTL and testbench

- Two-input, 5-bit-wide word multiplexer: selects one of two 5-bit buses (10 data bits in, 5 out) onto a single output.
- Combinational path is zero-latency.
- A registered copy with a valid flag is provided for pipelined consumers in the adder datapaths (e.g. carry-select stages).
- Datapath is a row of per-bit 2:1 mux slices.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_2to1.sv | 23 ++
 rtl/mux_10to5.sv | 89 ++++++++
 tb/tb_mux_10to5.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the mux_10to5 word multiplexer.
//   MUX_DEFAULT_WIDTH : default data width of each input bus and the output
//   SEL_IN0 / SEL_IN1 : select encodings for the two input channels
package mux_pkg;

  localparam int unsigned MUX_DEFAULT_WIDTH = 5;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_2to1.sv
// One-bit 2:1 mux slice built from gate primitives.
// Ports:
//   a   : bit routed to y when sel=0
//   b   : bit routed to y when sel=1
//   sel : channel select
//   y   : (a & ~sel) | (b & sel)
module mux_2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  logic sel_n;
  logic a_term;
  logic b_term;

  not u_not_sel (sel_n, sel);
  and u_and_a   (a_term, a, sel_n);
  and u_and_b   (b_term, b, sel);
  or  u_or_y    (y, a_term, b_term);

endmodule : mux_2to1

// File: rtl/mux_10to5.sv
// Two-input word multiplexer with a zero-latency combinational output and a
// registered copy plus valid flag for pipelined consumers.
// Optional feature macro: MUX_10TO5_PARITY_EN adds a registered even-parity
// bit (parity_q) of the captured word.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset of the register stage
//   in0, in1      : data words for select=0 / select=1
//   select        : channel select
//   in_valid      : qualifies the current word for capture
//   channel_out   : combinational mux result
//   channel_out_q : registered mux result (holds while in_valid=0)
//   out_valid     : channel_out_q was captured on the previous edge
//   parity_q      : XOR reduction of the captured word (only with the macro)
module mux_10to5
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] channel_out,
  output logic [WIDTH-1:0] channel_out_q,
`ifdef MUX_10TO5_PARITY_EN
  output logic             parity_q,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] channel_out_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // Row of per-bit mux slices forming the combinational datapath
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
    mux_2to1 u_slice (
      .a   (in0[i]),
      .b   (in1[i]),
      .sel (select),
      .y   (channel_out[i])
    );
  end

  // Capture the mux result on valid cycles; the word holds otherwise
  always_comb begin
    channel_out_d = channel_out_q;
    out_valid_d   = 1'b0;
    if (in_valid) begin
      channel_out_d = channel_out;
      out_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      channel_out_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      channel_out_q <= channel_out_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

`ifdef MUX_10TO5_PARITY_EN
  logic parity_d;

  // Even-parity bit tracks the captured word
  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      parity_d = ^channel_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule : mux_10to5

// File: tb/tb_mux_10to5.sv
// Self-checking bench for mux_10to5: directed vector table, reset and
// select-timing sequences, and a full combinational sweep.
module tb_mux_10to5;

  import mux_pkg::*;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         select;
  logic         in_valid;
  logic [W-1:0] channel_out;
  logic [W-1:0] channel_out_q;
  logic         out_valid;
`ifdef MUX_10TO5_PARITY_EN
  logic         parity_q;
`endif

  int n_cmp;
  int n_err;

  mux_10to5 #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in0           (in0),
    .in1           (in1),
    .select        (select),
    .in_valid      (in_valid),
    .channel_out   (channel_out),
    .channel_out_q (channel_out_q),
`ifdef MUX_10TO5_PARITY_EN
    .parity_q      (parity_q),
`endif
    .out_valid     (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         sel;
    logic         vld;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_q;
    logic         exp_vld;
    logic         exp_par;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs[8];

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in0      = '0;
    in1      = '0;
    select   = SEL_IN0;
    in_valid = 1'b0;

    // Hand-computed vectors; rows are cumulative (held word carries over)
    vecs[0] = '{5'b10011, 5'b01100, 1'b0, 1'b1, 5'b10011, 5'b10011, 1'b1, 1'b1};
    vecs[1] = '{5'b11111, 5'b00001, 1'b1, 1'b1, 5'b00001, 5'b00001, 1'b1, 1'b1};
    vecs[2] = '{5'b10101, 5'b10101, 1'b1, 1'b1, 5'b10101, 5'b10101, 1'b1, 1'b1};
    vecs[3] = '{5'b10101, 5'b10101, 1'b0, 1'b0, 5'b10101, 5'b10101, 1'b0, 1'b1};
    vecs[4] = '{5'b00000, 5'b11111, 1'b1, 1'b0, 5'b11111, 5'b10101, 1'b0, 1'b1};
    vecs[5] = '{5'b01110, 5'b10001, 1'b0, 1'b0, 5'b01110, 5'b10101, 1'b0, 1'b1};
    vecs[6] = '{5'b00000, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00000, 1'b1, 1'b0};
    vecs[7] = '{5'b11111, 5'b11111, 1'b1, 1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1};

    // Power-on reset
    #1 rst = 1'b1;
    #1;
    check("reset_q", 64'(channel_out_q), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
`ifdef MUX_10TO5_PARITY_EN
    check("reset_parity", 64'(parity_q), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[k]) begin
      @(negedge clk);
      in0      = vecs[k].in0;
      in1      = vecs[k].in1;
      select   = vecs[k].sel;
      in_valid = vecs[k].vld;
      #1;
      check($sformatf("vec%0d_comb", k), 64'(channel_out), 64'(vecs[k].exp_out));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", k), 64'(channel_out_q), 64'(vecs[k].exp_q));
      check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vecs[k].exp_vld));
`ifdef MUX_10TO5_PARITY_EN
      check($sformatf("vec%0d_parity", k), 64'(parity_q), 64'(vecs[k].exp_par));
`endif
    end

    // Asynchronous reset mid-cycle while 11111 is held
    @(negedge clk);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", 64'(channel_out_q), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    in0    = 5'b00110;
    in1    = 5'b11000;
    select = SEL_IN1;
    #1;
    check("rst_comb_follows", 64'(channel_out), 64'(5'b11000));
    @(posedge clk);
    #1;
    check("rst_hold_q", 64'(channel_out_q), 64'd0);
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in0      = 5'b01010;
    in1      = 5'b10111;
    select   = SEL_IN0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_q", 64'(channel_out_q), 64'(5'b01010));
    check("post_rst_valid", 64'(out_valid), 64'd1);
`ifdef MUX_10TO5_PARITY_EN
    check("post_rst_parity", 64'(parity_q), 64'd0);
`endif

    // Select changes just before the edge: the value at the edge is captured
    @(negedge clk);
    in0    = 5'b00011;
    in1    = 5'b11100;
    select = SEL_IN0;
    #2 select = SEL_IN1;
    @(posedge clk);
    #1;
    check("sel_toggle_q", 64'(channel_out_q), 64'(5'b11100));
    check("sel_toggle_valid", 64'(out_valid), 64'd1);
`ifdef MUX_10TO5_PARITY_EN
    check("sel_toggle_parity", 64'(parity_q), 64'd1);
`endif

    // Exhaustive combinational sweep over (select, in1, in0)
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] pat;
      logic [W-1:0] ref_out;
      pat    = 11'(i);
      in0    = pat[4:0];
      in1    = pat[9:5];
      select = pat[10];
      ref_out = (pat[4:0] & {W{~pat[10]}}) | (pat[9:5] & {W{pat[10]}});
      #1;
      check($sformatf("sweep_%0d", i), 64'(channel_out), 64'(ref_out));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_10to5
